// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan_driver: enable, six decimal digit fields in,
// active-low anode/cathode drive and frame pulse out.
interface seg_scan_if;
    logic       en;
    logic [5:0] hrstens;
    logic [5:0] hrsones;
    logic [5:0] mintens;
    logic [5:0] minones;
    logic [5:0] sectens;
    logic [5:0] secones;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output en, hrstens, hrsones, mintens, minones, sectens, secones,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  en, hrstens, hrsones, mintens, minones, sectens, secones,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 6-digit 7-segment scan driver with inter-digit blanking and per-frame snapshots.
// Optional build macro LEADING_ZERO_BLANK_EN darkens the hours-tens digit when it is zero.
module seg_scan_driver #(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    seg_scan_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [2:0]    IDX_LAST   = 3'd5;

    typedef enum logic {
        BLANK,
        DRIVE
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    shd_q [6];
    logic [5:0]    shd_d [6];
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          tick_q, tick_d;
    logic          dark;

    function automatic logic [6:0] decode(input logic [5:0] v);
        logic [6:0] s;
        case (v)
            6'd0:    s = 7'h40;
            6'd1:    s = 7'h79;
            6'd2:    s = 7'h24;
            6'd3:    s = 7'h30;
            6'd4:    s = 7'h19;
            6'd5:    s = 7'h12;
            6'd6:    s = 7'h02;
            6'd7:    s = 7'h78;
            6'd8:    s = 7'h00;
            6'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        shd_d   = shd_q;
        tick_d  = 1'b0;

        if (!bus.en) begin
            state_d = BLANK;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                BLANK: begin
                    if (idx_q == '0 && cnt_q == '0) begin
                        shd_d[0] = bus.secones;
                        shd_d[1] = bus.sectens;
                        shd_d[2] = bus.minones;
                        shd_d[3] = bus.mintens;
                        shd_d[4] = bus.hrsones;
                        shd_d[5] = bus.hrstens;
                        tick_d   = 1'b1;
                    end
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_q == DIGIT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are derived from next-state so they switch on the same edge as the FSM;
    // shd_d is used so a one-clock blank still shows the freshly captured digit.
    always_comb begin
        an_d  = '1;
        seg_d = '1;
`ifdef LEADING_ZERO_BLANK_EN
        dark = (idx_d == IDX_LAST) && (shd_d[5] == '0);
`else
        dark = 1'b0;
`endif
        if (state_d == DRIVE && !dark) begin
            an_d[idx_d] = 1'b0;
            seg_d       = decode(shd_d[idx_d]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BLANK;
            idx_q   <= '0;
            cnt_q   <= '0;
            an_q    <= '1;
            seg_q   <= '1;
            tick_q  <= 1'b0;
            for (int unsigned i = 0; i < 6; i++) begin
                shd_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
            shd_q   <= shd_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed and random stimulus checked against a frame-phase model.
module tb_seg_scan_driver;

    localparam int D     = 4;
    localparam int B     = 2;
    localparam int SLOT  = B + D;
    localparam int FRAME = 6 * SLOT;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_r;
    logic [5:0] dig [6];

    always #5 clk = ~clk;

    seg_scan_if bus();

    assign bus.en      = en_r;
    assign bus.secones = dig[0];
    assign bus.sectens = dig[1];
    assign bus.minones = dig[2];
    assign bus.mintens = dig[3];
    assign bus.hrsones = dig[4];
    assign bus.hrstens = dig[5];

    seg_scan_driver #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         total = 0;
    int         bad   = 0;
    int         ph    = 0;
    logic [5:0] shd [6];
    logic       tick_e = 1'b0;
    logic [6:0] DEC [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] dec(input logic [5:0] v);
        return (v < 6'd10) ? DEC[v[3:0]] : 7'h3F;
    endfunction

    function automatic logic slot_dark();
        int slot = ph / SLOT;
        if (ph % SLOT < B) return 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 5 && shd[5] == 6'd0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_an();
        logic [7:0] one = 8'h01;
        if (slot_dark()) return 8'hFF;
        return ~(one << (ph / SLOT));
    endfunction

    function automatic logic [6:0] exp_seg();
        if (slot_dark()) return 7'h7F;
        return dec(shd[ph / SLOT]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h ph=%0d t=%0t", tag, obs, exp, ph, $time);
        end
    endtask

    task automatic check_outs();
        chk("an", 32'(bus.an), 32'(exp_an()));
        chk("seg", 32'(bus.seg), 32'(exp_seg()));
        chk("dp", 32'(bus.dp), 32'd1);
        chk("frame_tick", 32'(bus.frame_tick), 32'(tick_e));
    endtask

    task automatic model_reset();
        ph     = 0;
        tick_e = 1'b0;
        for (int i = 0; i < 6; i++) shd[i] = 6'd0;
    endtask

    // Model: ph is clocks elapsed in the current frame; a frame starts when an
    // enabled edge sees ph==0, which is also the snapshot edge.
    task automatic step();
        @(posedge clk);
        tick_e = 1'b0;
        if (!en_r) begin
            ph = 0;
        end else begin
            if (ph == 0) begin
                for (int i = 0; i < 6; i++) shd[i] = dig[i];
                tick_e = 1'b1;
            end
            ph = (ph + 1) % FRAME;
        end
        #1;
        check_outs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int target);
        int k = 0;
        while (ph != target && k < 2 * FRAME) begin
            step();
            k++;
        end
        total++;
        assert (ph == target) else begin
            bad++;
            $error("FAIL run_to_bound phase=%0d required=%0d", ph, target);
        end
    endtask

    initial begin
        reset = 1'b1;
        en_r  = 1'b0;
        for (int i = 0; i < 6; i++) dig[i] = 6'd0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_outs();

        // Release with digits 1..6 on hrstens..secones.
        dig[5] = 6'd1; dig[4] = 6'd2; dig[3] = 6'd3;
        dig[2] = 6'd4; dig[1] = 6'd5; dig[0] = 6'd6;
        reset = 1'b0;
        en_r  = 1'b1;
        run(2 * FRAME + 4);

        // Mid-frame input change during the idx=3 slot.
        run_to(3 * SLOT + B + 1);
        dig[0] = 6'd7;
        run(2 * FRAME);

        // Out-of-range shadows.
        dig[0] = 6'd12;
        dig[3] = 6'd63;
        run(2 * FRAME);

        // Disable during the idx=2 drive slot.
        run_to(2 * SLOT + B);
        en_r = 1'b0;
        run(10);
        en_r = 1'b1;
        run(FRAME + 6);

        // Leading zero on hours tens.
        dig[5] = 6'd0;
        dig[4] = 6'd9;
        dig[3] = 6'd0; dig[2] = 6'd5; dig[1] = 6'd0; dig[0] = 6'd7;
        run(2 * FRAME);

        // Random digits and enable drops.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 7) == 0) dig[$urandom_range(0, 5)] = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0) dig[5] = 6'd0;
            if (en_r && $urandom_range(0, 59) == 0) en_r = 1'b0;
            else if (!en_r && $urandom_range(0, 3) == 0) en_r = 1'b1;
            step();
        end
        en_r = 1'b1;

        // Asynchronous reset mid-frame.
        run_to(SLOT + B + 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_outs();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        reset = 1'b0;
        run(FRAME + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
